// File: rtl/pipe_stage_elastic_if.sv
// Handshake bundle for the elastic pipeline chain: upstream offer and downstream accept.
// Ports: in_valid/in_ready/in_data face the producer, out_valid/out_ready/out_data face the consumer.
// The slave modport is the chain itself; the master modport is the environment around it.
interface pipe_stage_elastic_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/pipe_stage_elastic.sv
// Elastic chain of DEPTH payload registers, per-stage valid, bubbles collapse, global stall/flush.
// Latency: DEPTH-1 edges from acceptance to the output stage; 1 transfer/cycle sustained.
// Backpressure: in_ready is combinational from out_ready through the advance chain.
// Ports: CLK, RST (async active-low), bus (slave: in_*/out_* handshake), stall, flush, count.
module pipe_stage_elastic #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  pipe_stage_elastic_if.slave        bus,
  input  logic                       stall,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] r_v;
  logic [WIDTH-1:0] r_d [DEPTH];
  logic [CW-1:0]    r_count;

  logic             w_run;
  logic [DEPTH-1:0] w_adv;
  logic [DEPTH-1:0] w_load;
  logic [DEPTH-1:0] w_v_nxt;
  logic [CW-1:0]    w_cnt_nxt;

  assign w_run = !flush && !stall;

  // Advance resolves from the output end backwards: a stage moves if the
  // one ahead is empty or is itself moving this cycle.
  always_comb begin
    w_adv = '0;
    w_adv[DEPTH-1] = r_v[DEPTH-1] & bus.out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      w_adv[i] = r_v[i] & (!r_v[i+1] | w_adv[i+1]);
    end
  end

  // A stage can take a new occupant when empty or when its occupant leaves;
  // an empty stage therefore fills even while the stage ahead is blocked.
  assign w_load = ~r_v | w_adv;

  always_comb begin
    w_v_nxt = r_v;
    if (flush) begin
      w_v_nxt = '0;
    end else if (!stall) begin
      if (w_load[0]) begin
        w_v_nxt[0] = bus.in_valid;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (w_load[i]) begin
          w_v_nxt[i] = r_v[i-1];
        end
      end
    end
  end

  // count is the population of the valid vector the next edge will hold.
  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_cnt_nxt = w_cnt_nxt + CW'(w_v_nxt[i]);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_v     <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_d[i] <= '0;
      end
    end else begin
      r_v     <= w_v_nxt;
      r_count <= w_cnt_nxt;
      // Data only moves with a valid occupant, so a stage that goes empty
      // keeps its previous contents.
      if (w_run) begin
        if (w_load[0] && bus.in_valid) begin
          r_d[0] <= bus.in_data;
        end
        for (int i = 1; i < DEPTH; i++) begin
          if (w_load[i] && r_v[i-1]) begin
            r_d[i] <= r_d[i-1];
          end
        end
      end
    end
  end

  // Handshake outputs are forced low during reset and during stall/flush.
  assign bus.in_ready  = RST & w_run & w_load[0];
  assign bus.out_valid = RST & w_run & r_v[DEPTH-1];
  assign bus.out_data  = r_d[DEPTH-1];
  assign count         = r_count;
endmodule

// File: tb/tb_pipe_stage_elastic.sv
module tb_pipe_stage_elastic;
  localparam int W = 32;
  localparam int D = 3;

  logic         CLK;
  logic         RST;
  logic         stall;
  logic         flush;
  logic [1:0]   count;

  pipe_stage_elastic_if #(.WIDTH(W)) bus ();

  pipe_stage_elastic #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .bus   (bus),
    .stall (stall),
    .flush (flush),
    .count (count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: ordered list of in-flight entries (oldest first), each
  // with its payload and the stage position it currently occupies.
  int unsigned mpos [$];
  logic [31:0] mdat [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called a little after the falling edge: drives inputs, checks the DUT
  // against the model, then advances the model over the rising edge.
  task automatic cycle(input bit iv, input logic [31:0] id, input bit ordy, input bit st, input bit fl);
    bit mv [$];
    bit raw_ir, e_ir, e_ov;
    int n;
    int unsigned npos [$];
    logic [31:0] ndat [$];
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    stall         = st;
    flush         = fl;
    #1;
    n = mpos.size();
    for (int k = 0; k < n; k++) begin
      if (k == 0) mv.push_back((mpos[0] == D - 1) ? ordy : 1'b1);
      else        mv.push_back((mpos[k] + 1 != mpos[k-1]) || mv[k-1]);
    end
    if (n == 0) raw_ir = 1'b1;
    else        raw_ir = (mpos[n-1] != 0) || mv[n-1];
    e_ir = raw_ir && !st && !fl;
    e_ov = (n > 0) && (mpos[0] == D - 1) && !st && !fl;
    check("in_ready", {31'd0, bus.in_ready}, {31'd0, e_ir});
    check("out_valid", {31'd0, bus.out_valid}, {31'd0, e_ov});
    if (e_ov) check("out_data", bus.out_data, mdat[0]);
    check("count", {30'd0, count}, 32'(n));
    @(posedge CLK);
    if (fl) begin
      mpos.delete();
      mdat.delete();
    end else if (!st) begin
      for (int k = 0; k < n; k++) begin
        if (!(k == 0 && mpos[0] == D - 1 && mv[0])) begin
          npos.push_back(mpos[k] + (mv[k] ? 1 : 0));
          ndat.push_back(mdat[k]);
        end
      end
      if (iv && e_ir) begin
        npos.push_back(0);
        ndat.push_back(id);
      end
      mpos = npos;
      mdat = ndat;
    end
    @(negedge CLK);
  endtask

  initial begin
    RST           = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hDEAD_BEEF;
    bus.out_ready = 1'b1;
    stall         = 1'b0;
    flush         = 1'b0;
    #2;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_count", {30'd0, count}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;

    // Streaming with no backpressure.
    for (int i = 1; i <= 6; i++) cycle(1'b1, 32'(i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Fill against backpressure, then drain.
    cycle(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hD, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Bubble collapse behind a blocked head.
    cycle(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Stall with two entries in flight.
    cycle(1'b1, 32'h51, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 32'h52, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h5F, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Flush a full chain while both sides try to transfer.
    cycle(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h12, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h13, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset between edges with two entries held.
    cycle(1'b1, 32'h21, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    check("pre_rst_out_valid", {31'd0, bus.out_valid}, 32'd1);
    RST = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("arst_count", {30'd0, count}, 32'd0);
    check("arst_out_data", bus.out_data, 32'd0);
    check("arst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    mpos.delete();
    mdat.delete();
    #1;
    RST = 1'b1;
    cycle(1'b1, 32'h30, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 24) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_stage_elastic.md
# pipe_stage_elastic

Parametrised, elastic pipeline-register chain for the pipelined CPU datapath: a WIDTH-bit payload travels through DEPTH register stages under a valid/ready handshake. Each stage has its own valid bit, bubbles collapse, and there are global stall and flush controls. It replaces the fixed, always-enabled inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). Hazard and branch logic can then stall or squash in-flight instructions without losing throughput.

## Interface
Parameters:
- WIDTH, 32, payload width in bits (≥1).
- DEPTH, 2, number of register stages (≥1).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  chain accepts in_data this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  stage DEPTH-1 holds valid data, presented downstream.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  WIDTH  payload of stage DEPTH-1.
- stall  in  1  freeze the entire chain this cycle.
- flush  in  1  squash every in-flight entry.
- count  out  $clog2(DEPTH+1)  number of valid stages, registered.

## Operation
- State per stage i (0 = input end, DEPTH-1 = output end): v[i], d[i].
- Transfers:
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
- Advance, computed combinationally from the output end:
  - adv[DEPTH-1] = v[DEPTH-1] & out_ready.
  - adv[i] = v[i] & (!v[i+1] | adv[i+1]).
- Per-stage update when neither flush nor stall is active:
  - Stage i>0 loads d[i-1] and v[i-1] when !v[i] | adv[i].
  - Stage 0 loads in_data and in_valid under the same condition.
  - A stage whose valid is cleared keeps its old data. Data content when v=0 is don't-care but deterministic.
- Bubble collapse: an empty stage is filled from the stage behind it even if the stage ahead is stalled by backpressure.
- Control signals while neither flush nor stall is active:
  - in_ready = !v[0] | adv[0].
  - out_valid = v[DEPTH-1].
- Stall (flush=0, stall=1):
  - in_ready=0 and out_valid=0.
  - No v/d change and no transfer occurs.
- Flush (priority over stall):
  - in_ready=0 and out_valid=0.
  - All v[i] clear at the next edge; d is untouched.
  - Input is not accepted in the flush cycle.
- count equals the number of v[i] set after each edge, in the range 0..DEPTH.
- Reset (RST=0), immediate and asynchronous:
  - All v=0, all d=0, count=0.
  - While RST=0: in_ready=0, out_valid=0, out_data=0.
  - Reset mid-transfer discards all entries. No partial state survives.

## Timing
- Latency: an entry accepted at edge k with no backpressure reaches stage DEPTH-1 at edge k+DEPTH-1, so out_valid is high during the cycle after edge k+DEPTH-1.
- Throughput: 1 transfer/cycle sustained when out_ready=1.
- in_ready and out_valid are combinational from state and the control inputs. The ready chain is a combinational path from out_ready to in_ready, DEPTH levels deep.
- Full: all v set and out_ready=0 gives in_ready=0. With out_ready=1 on a full chain, in_ready=1, so a simultaneous input and output transfer keeps the chain full.
- Empty: count=0 and out_valid=0; in_ready=1 (absent stall/flush).
- Simultaneous flush with in_valid/out_ready: no transfer on either side and the chain empties.
- After RST deasserts: in_ready=1 from the first cycle; the first edge may accept data.
- DEPTH=1 degenerates to a single stage with the same rules.

## Test plan
- Streaming, WIDTH=32, DEPTH=3, out_ready=1: present 0x1,0x2,0x3,… on consecutive cycles. Word 0x1 appears at out_data 2 edges after acceptance, then one word per cycle in order, with count=3 in steady state.
- Fill/backpressure: out_ready=0, push 0xA,0xB,0xC. in_ready falls after the third accept and count=3. Raise out_ready: outputs 0xA,0xB,0xC in order, with in_ready=1 in the same cycle the first word leaves.
- Bubble collapse: load 0xA only, hold out_ready=0 for 4 cycles, then push 0xB. 0xB advances to stage 1 directly behind 0xA, and count=2 after 2 edges.
- Stall: mid-stream with 2 entries, assert stall for 3 cycles. in_ready=0, out_valid=0, count is unchanged, and the data order is intact after release.
- Flush: chain full with 0x10,0x11,0x12, flush=1 together with in_valid=1 (0x13) and out_ready=1. Next cycle count=0, out_valid=0, and neither 0x12 nor 0x13 ever appears downstream.
- Reset mid-operation: with 2 entries, pulse RST low between edges. out_valid and count drop to 0 immediately without waiting for a clock edge, out_data=0, and in_ready=1 on the first cycle after release.
